// File: rtl/vram_wr_arb.sv
// vram_wr_arb: write front-end for the character generator VRAM port.
// CPU byte writes are queued in a small FIFO. A screen-clear command sweeps the
// whole address space with a fill code. Both sources drain onto a single
// registered VRAM write port at the CK_EE_i rate, and only while WR_WIN_i is open.
// Optional feature macro: VRAM_WR_ARB_OVF_STICKY_EN (sticky overflow flag on OVF_o).
module vram_wr_arb #(
  parameter int C_AW        = 10,
  parameter int C_DW        = 8,
  parameter int C_FIFO_LOG2 = 3
) (
  input  logic            CK_i,
  input  logic            XAR_i,
  input  logic            CK_EE_i,
  input  logic            WR_WIN_i,
  input  logic            PUSH_i,
  input  logic [C_DW-1:0] PUSH_WDs_i,
  input  logic [C_AW-1:0] PUSH_WAs_i,
  input  logic            CLR_REQ_i,
  input  logic [C_DW-1:0] CLR_CODEs_i,
  output logic            FULL_o,
  output logic            EMPTY_o,
  output logic            BUSY_o,
  output logic            DONE_o,
  output logic            OVF_o,
  output logic [C_DW-1:0] VRAM_WDs_o,
  output logic [C_AW-1:0] VRAM_WAs_o,
  output logic            VRAM_WE_o
);

  localparam int DEPTH = 1 << C_FIFO_LOG2;
  localparam logic [C_FIFO_LOG2:0] DEPTH_CNT = (C_FIFO_LOG2+1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t state, state_nxt;

  // FIFO storage and bookkeeping
  logic [C_DW-1:0]        fifo_wd [DEPTH];
  logic [C_AW-1:0]        fifo_wa [DEPTH];
  logic [C_FIFO_LOG2-1:0] wr_ptr;
  logic [C_FIFO_LOG2-1:0] rd_ptr;
  logic [C_FIFO_LOG2:0]   count;

  // Clear sweep state
  logic [C_DW-1:0] clr_code;
  logic [C_AW-1:0] clr_addr;

  // Registered VRAM port and status
  logic [C_DW-1:0] vram_wd_q;
  logic [C_AW-1:0] vram_wa_q;
  logic            vram_we_q;
  logic            done_q;

  logic full;
  logic empty;
  logic pop;
  logic push_ok;
  logic write_clear;
  logic clr_last;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // A pending clear request always wins over a FIFO pop on the same edge.
  assign pop         = CK_EE_i && WR_WIN_i && (state == IDLE) && !empty && !CLR_REQ_i;
  assign push_ok     = PUSH_i && (!full || pop);
  assign write_clear = CK_EE_i && WR_WIN_i && (state == CLEAR) && !CLR_REQ_i;
  assign clr_last    = write_clear && (clr_addr == '1);

  // FIFO entry storage; contents need no reset because the pointers define validity
  always_ff @(posedge CK_i) begin
    if (push_ok) begin
      fifo_wd[wr_ptr] <= PUSH_WDs_i;
      fifo_wa[wr_ptr] <= PUSH_WAs_i;
    end
  end

  // FIFO pointers and occupancy count; pointers wrap naturally at the depth
  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register
  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a clear request enters or restarts CLEAR, the last sweep write leaves it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (CLR_REQ_i) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        if (CLR_REQ_i) begin
          state_nxt = CLEAR;
        end else if (clr_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear code latch and sweep address counter; the counter only moves on real writes
  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      clr_code <= '0;
      clr_addr <= '0;
    end else if (CLR_REQ_i) begin
      clr_code <= CLR_CODEs_i;
      clr_addr <= '0;
    end else if (write_clear) begin
      clr_addr <= clr_addr + 1'b1;
    end
  end

  // VRAM write port: updated only on CK_EE_i edges so WE stays up for a full enable period
  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      vram_wd_q <= '0;
      vram_wa_q <= '0;
      vram_we_q <= 1'b0;
    end else if (CK_EE_i) begin
      if (pop) begin
        vram_wd_q <= fifo_wd[rd_ptr];
        vram_wa_q <= fifo_wa[rd_ptr];
        vram_we_q <= 1'b1;
      end else if (write_clear) begin
        vram_wd_q <= clr_code;
        vram_wa_q <= clr_addr;
        vram_we_q <= 1'b1;
      end else begin
        vram_we_q <= 1'b0;
      end
    end
  end

  // Single-cycle completion pulse on the edge that writes the final sweep address
  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      done_q <= 1'b0;
    end else begin
      done_q <= clr_last;
    end
  end

`ifdef VRAM_WR_ARB_OVF_STICKY_EN
  logic drop;
  logic ovf_q;

  assign drop = PUSH_i && full && !pop;

  // Sticky overflow: a fresh drop takes precedence over a clear on the same edge
  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (CLR_REQ_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign OVF_o = ovf_q;
`else
  assign OVF_o = 1'b0;
`endif

  assign FULL_o     = full;
  assign EMPTY_o    = empty;
  assign BUSY_o     = (state == CLEAR);
  assign DONE_o     = done_q;
  assign VRAM_WDs_o = vram_wd_q;
  assign VRAM_WAs_o = vram_wa_q;
  assign VRAM_WE_o  = vram_we_q;

endmodule

// File: tb/tb_vram_wr_arb.sv
// tb_vram_wr_arb: directed self-checking bench for vram_wr_arb.
// CK_EE_i is produced here as one cycle in four; all inputs change and all
// outputs are sampled on the falling edge of CK_i.
module tb_vram_wr_arb;

  localparam int C_AW        = 10;
  localparam int C_DW        = 8;
  localparam int C_FIFO_LOG2 = 3;
  localparam int N_ADDR      = 1 << C_AW;

`ifdef VRAM_WR_ARB_OVF_STICKY_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic            ck = 1'b0;
  logic            xar = 1'b0;
  logic            ck_ee = 1'b0;
  logic            wr_win = 1'b0;
  logic            push = 1'b0;
  logic [C_DW-1:0] push_wd = '0;
  logic [C_AW-1:0] push_wa = '0;
  logic            clr_req = 1'b0;
  logic [C_DW-1:0] clr_code = '0;

  logic            full;
  logic            empty;
  logic            busy;
  logic            done;
  logic            ovf;
  logic [C_DW-1:0] wd;
  logic [C_AW-1:0] wa;
  logic            we;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;
  int phase    = 0;

  typedef struct {
    logic [C_AW-1:0] wa;
    logic [C_DW-1:0] wd;
    logic            exp_full;
    logic            exp_empty;
  } vec_t;

  vec_t vecs [9];

  vram_wr_arb #(
    .C_AW        (C_AW),
    .C_DW        (C_DW),
    .C_FIFO_LOG2 (C_FIFO_LOG2)
  ) dut (
    .CK_i        (ck),
    .XAR_i       (xar),
    .CK_EE_i     (ck_ee),
    .WR_WIN_i    (wr_win),
    .PUSH_i      (push),
    .PUSH_WDs_i  (push_wd),
    .PUSH_WAs_i  (push_wa),
    .CLR_REQ_i   (clr_req),
    .CLR_CODEs_i (clr_code),
    .FULL_o      (full),
    .EMPTY_o     (empty),
    .BUSY_o      (busy),
    .DONE_o      (done),
    .OVF_o       (ovf),
    .VRAM_WDs_o  (wd),
    .VRAM_WAs_o  (wa),
    .VRAM_WE_o   (we)
  );

  // 10-unit clock period
  always #5 ck = ~ck;

  // Hard time limit so the run can never hang
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: time limit reached before the summary");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One CK_i cycle: advance the enable phase and count DONE pulses
  task automatic cycle();
    @(negedge ck);
    phase = (phase + 1) % 4;
    ck_ee = (phase == 3);
    if (done === 1'b1) done_cnt++;
  endtask

  // Advance until one CK_EE_i rising edge has passed
  task automatic ee_edge();
    logic fired;
    do begin
      fired = ck_ee;
      cycle();
    end while (!fired);
  endtask

  task automatic applyStimulus(input logic p, input logic [C_AW-1:0] a, input logic [C_DW-1:0] d);
    push    = p;
    push_wa = a;
    push_wd = d;
    cycle();
    push    = 1'b0;
  endtask

  task automatic pulseClear(input logic [C_DW-1:0] code);
    clr_code = code;
    clr_req  = 1'b1;
    cycle();
    clr_req  = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_empty"}, empty, 1);
    checkOutput({tag, "_full"},  full,  0);
    checkOutput({tag, "_busy"},  busy,  0);
    checkOutput({tag, "_done"},  done,  0);
    checkOutput({tag, "_ovf"},   ovf,   0);
    checkOutput({tag, "_wd"},    wd,    0);
    checkOutput({tag, "_wa"},    wa,    0);
    checkOutput({tag, "_we"},    we,    0);
  endtask

  // Full clear sweep against a model address counter; optional window toggling and restart
  task automatic runClear(input logic [C_DW-1:0] code, input int toggle,
                          input int restart_at, input logic [C_DW-1:0] code2);
    int   exp_a    = 0;
    int   bad_wr   = 0;
    int   bad_busy = 0;
    int   period   = 0;
    int   guard    = 0;
    int   done0;
    bit   restarted = 0;
    logic [C_DW-1:0] cur = code;
    logic empty_before;
    ee_edge();
    empty_before = empty;
    done0  = done_cnt;
    wr_win = 1'b1;
    pulseClear(code);
    checkOutput("clr_busy_start", busy, 1);
    while (exp_a < N_ADDR && guard < 5000) begin
      guard++;
      if (toggle > 0) wr_win = ((period / toggle) % 2 == 0);
      period++;
      ee_edge();
      if (wr_win) begin
        if (!(we === 1'b1 && wa === exp_a[C_AW-1:0] && wd === cur)) bad_wr++;
        exp_a++;
      end else if (we !== 1'b0) begin
        bad_wr++;
      end
      if (exp_a < N_ADDR && busy !== 1'b1) bad_busy++;
      if (!restarted && restart_at > 0 && exp_a == restart_at) begin
        restarted = 1;
        pulseClear(code2);
        cur   = code2;
        exp_a = 0;
      end
    end
    wr_win = 1'b0;
    checkOutput("clr_completed", exp_a, N_ADDR);
    checkOutput("clr_writes_bad", bad_wr, 0);
    checkOutput("clr_busy_bad", bad_busy, 0);
    checkOutput("clr_done_at_end", done_cnt - done0, 1);
    checkOutput("clr_busy_end", busy, 0);
    repeat (8) cycle();
    checkOutput("clr_done_single", done_cnt - done0, 1);
    checkOutput("clr_fifo_untouched", empty, empty_before);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) begin
      vecs[i].wa        = C_AW'(10'h100 + i * 3);
      vecs[i].wd        = C_DW'(8'hA0 + i);
      vecs[i].exp_full  = (i >= 7);
      vecs[i].exp_empty = 1'b0;
    end

    // Reset state
    repeat (3) cycle();
    checkReset("rst");
    xar = 1'b1;
    repeat (2) cycle();

    // Two pushes drain on consecutive enable periods
    wr_win = 1'b1;
    ee_edge();
    applyStimulus(1'b1, 10'h005, 8'h41);
    applyStimulus(1'b1, 10'h006, 8'h42);
    ee_edge();
    checkOutput("two_w1_we", we, 1);
    checkOutput("two_w1_wa", wa, 10'h005);
    checkOutput("two_w1_wd", wd, 8'h41);
    checkOutput("two_w1_empty", empty, 0);
    ee_edge();
    checkOutput("two_w2_we", we, 1);
    checkOutput("two_w2_wa", wa, 10'h006);
    checkOutput("two_w2_wd", wd, 8'h42);
    checkOutput("two_w2_empty", empty, 1);
    ee_edge();
    checkOutput("two_idle_we", we, 0);
    checkOutput("two_idle_wa", wa, 10'h006);

    // Fill past depth with the window closed, then drain in order
    wr_win = 1'b0;
    ee_edge();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, vecs[i].wa, vecs[i].wd);
      checkOutput($sformatf("fill%0d_full", i), full, vecs[i].exp_full);
      checkOutput($sformatf("fill%0d_empty", i), empty, vecs[i].exp_empty);
    end
    checkOutput("fill_ovf", ovf, EXP_OVF);
    checkOutput("fill_no_write", we, 0);
    wr_win = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ee_edge();
      checkOutput($sformatf("drain%0d_we", i), we, 1);
      checkOutput($sformatf("drain%0d_wa", i), wa, vecs[i].wa);
      checkOutput($sformatf("drain%0d_wd", i), wd, vecs[i].wd);
    end
    ee_edge();
    checkOutput("drain_end_we", we, 0);
    checkOutput("drain_end_empty", empty, 1);
    checkOutput("drain_ovf_sticky", ovf, EXP_OVF);

    // Plain clear with one entry parked in the FIFO
    wr_win = 1'b0;
    ee_edge();
    applyStimulus(1'b1, 10'h3AB, 8'h5C);
    runClear(8'h20, 0, 0, 8'h00);
    checkOutput("clr_ovf_cleared", ovf, 0);
    wr_win = 1'b1;
    ee_edge();
    checkOutput("post_clr_we", we, 1);
    checkOutput("post_clr_wa", wa, 10'h3AB);
    checkOutput("post_clr_wd", wd, 8'h5C);
    checkOutput("post_clr_empty", empty, 1);
    wr_win = 1'b0;

    // Clear with the window toggling every 16 enable periods
    runClear(8'h55, 16, 0, 8'h00);

    // Clear restarted at address 0x200 with a new code
    runClear(8'h7E, 0, 10'h200, 8'h00);

    // Reset in the middle of a clear
    wr_win = 1'b1;
    ee_edge();
    pulseClear(8'h33);
    repeat (100) ee_edge();
    checkOutput("mid_busy", busy, 1);
    checkOutput("mid_wa", wa, 99);
    checkOutput("mid_wd", wd, 8'h33);
    begin
      int done0;
      done0 = done_cnt;
      xar = 1'b0;
      #1;
      checkReset("midrst");
      repeat (6) cycle();
      checkOutput("midrst_no_done", done_cnt - done0, 0);
    end
    xar = 1'b1;
    ee_edge();
    applyStimulus(1'b1, 10'h011, 8'h99);
    ee_edge();
    checkOutput("after_rst_we", we, 1);
    checkOutput("after_rst_wa", wa, 10'h011);
    checkOutput("after_rst_wd", wd, 8'h99);
    checkOutput("after_rst_busy", busy, 0);
    ee_edge();
    checkOutput("after_rst_empty", empty, 1);
    checkOutput("after_rst_idle_we", we, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
